// File: rtl/lru_replace_ctrl.sv
// Per-set LRU replacement controller for a 4-way cache: tracks the LRU matrix and
// valid bits for every set, picks refill victims, and runs the refill handshake.
module lru_replace_ctrl #(
  parameter int unsigned SET_BITS = 6
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [SET_BITS-1:0] req_index,
  input  logic                req_hit,
  input  logic [1:0]          req_hit_way,
  output logic                resp_valid,
  input  logic                resp_ready,
  output logic [1:0]          resp_way,
  output logic                resp_miss,
  output logic                refill_valid,
  input  logic                refill_ready,
  output logic [SET_BITS-1:0] refill_index,
  output logic [1:0]          refill_way,
  input  logic                refill_done,
  input  logic                flush_req,
  output logic                flush_busy
);
  localparam int unsigned NSETS = 1 << SET_BITS;

  typedef enum logic [2:0] {FLUSH, IDLE, REFILL_REQ, REFILL_WAIT, RESP} state_t;

  state_t state, state_nxt;

  logic [15:0] lru_mem   [NSETS];
  logic [3:0]  valid_mem [NSETS];

  logic [SET_BITS-1:0] cnt;
  logic [SET_BITS-1:0] lat_index;
  logic [1:0]          lat_way;
  logic                lat_miss;

  logic [SET_BITS-1:0] rd_index;
  logic [15:0]         rd_lru;
  logic [3:0]          rd_valid;
  logic                wr_en;
  logic [SET_BITS-1:0] wr_index;
  logic [15:0]         wr_lru;
  logic [3:0]          wr_valid;
  logic                accept;

  // Clear column w in every row, then fill row w with every bit except w.
  function automatic logic [15:0] lru_touch(input logic [15:0] old, input logic [1:0] w);
    logic [3:0] col;
    col = 4'b0001 << w;
    return (old & ~{4{col}}) | ({12'b0, ~col} << {w, 2'b00});
  endfunction

  function automatic logic [1:0] pick_victim(input logic [15:0] l, input logic [3:0] v);
    logic [1:0] vw;
    logic [2:0] best;
    logic [2:0] pc;
    logic       found;
    vw    = '0;
    found = 1'b0;
    best  = 3'd7;
    for (int unsigned i = 0; i < 4; i++) begin
      if (!v[i] && !found) begin
        vw    = 2'(i);
        found = 1'b1;
      end
    end
    if (!found) begin
      for (int unsigned i = 0; i < 4; i++) begin
        pc = 3'($countones(l[4*i +: 4]));
        if (pc < best) begin
          best = pc;
          vw   = 2'(i);
        end
      end
    end
    return vw;
  endfunction

  assign accept   = (state == IDLE) && !flush_req && req_valid;
  assign rd_index = (state == IDLE) ? req_index : lat_index;
  assign rd_lru   = lru_mem[rd_index];
  assign rd_valid = valid_mem[rd_index];

  always_comb begin
    wr_en    = 1'b0;
    wr_index = rd_index;
    wr_lru   = rd_lru;
    wr_valid = rd_valid;
    case (state)
      FLUSH: begin
        wr_en    = 1'b1;
        wr_index = cnt;
        wr_lru   = '0;
        wr_valid = '0;
      end
      IDLE: begin
        if (accept && req_hit) begin
          wr_en  = 1'b1;
          wr_lru = lru_touch(rd_lru, req_hit_way);
        end
      end
      REFILL_WAIT: begin
        if (refill_done) begin
          wr_en    = 1'b1;
          wr_lru   = lru_touch(rd_lru, lat_way);
          wr_valid = rd_valid | (4'b0001 << lat_way);
        end
      end
      default: ;
    endcase
  end

  // Writes are suppressed during reset so an aborted refill leaves no trace.
  always_ff @(posedge clk) begin
    if (wr_en && !rst) begin
      lru_mem[wr_index]   <= wr_lru;
      valid_mem[wr_index] <= wr_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= FLUSH;
      cnt       <= '0;
      lat_index <= '0;
      lat_way   <= '0;
      lat_miss  <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= (state == FLUSH) ? cnt + 1'b1 : '0;
      if (accept) begin
        lat_index <= req_index;
        lat_way   <= req_hit ? req_hit_way : pick_victim(rd_lru, rd_valid);
        lat_miss  <= 1'b0;
      end else if (state == REFILL_WAIT && refill_done) begin
        lat_miss <= 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      FLUSH:       if (cnt == '1) state_nxt = IDLE;
      IDLE: begin
        if (flush_req)      state_nxt = FLUSH;
        else if (req_valid) state_nxt = req_hit ? RESP : REFILL_REQ;
      end
      REFILL_REQ:  if (refill_ready) state_nxt = REFILL_WAIT;
      REFILL_WAIT: if (refill_done)  state_nxt = RESP;
      RESP:        if (resp_ready)   state_nxt = IDLE;
      default:     state_nxt = FLUSH;
    endcase
  end

  always_comb begin
    req_ready    = (state == IDLE) && !flush_req;
    resp_valid   = (state == RESP);
    refill_valid = (state == REFILL_REQ);
    flush_busy   = (state == FLUSH);
    resp_way     = lat_way;
    resp_miss    = lat_miss;
    refill_index = lat_index;
    refill_way   = lat_way;
  end
endmodule

// File: tb/tb_lru_replace_ctrl.sv
// Self-checking bench for lru_replace_ctrl: directed vector table, randomized traffic
// against a timestamp-based LRU model, plus flush and reset-abort sequences.
module tb_lru_replace_ctrl;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic [5:0] req_index = '0;
  logic       req_hit = 1'b0;
  logic [1:0] req_hit_way = '0;
  logic       resp_valid;
  logic       resp_ready = 1'b0;
  logic [1:0] resp_way;
  logic       resp_miss;
  logic       refill_valid;
  logic       refill_ready = 1'b0;
  logic [5:0] refill_index;
  logic [1:0] refill_way;
  logic       refill_done = 1'b0;
  logic       flush_req = 1'b0;
  logic       flush_busy;

  int total = 0;
  int bad   = 0;

  lru_replace_ctrl #(.SET_BITS(6)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_index(req_index),
    .req_hit(req_hit), .req_hit_way(req_hit_way),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_way(resp_way),
    .resp_miss(resp_miss),
    .refill_valid(refill_valid), .refill_ready(refill_ready),
    .refill_index(refill_index), .refill_way(refill_way), .refill_done(refill_done),
    .flush_req(flush_req), .flush_busy(flush_busy)
  );

  always #5 clk = ~clk;

  // Reference model: per-way last-use timestamps; LRU is the oldest timestamp.
  int unsigned last_use [64][4];
  bit          mv       [64][4];
  int unsigned tick = 0;

  function automatic void model_flush();
    for (int s = 0; s < 64; s++)
      for (int w = 0; w < 4; w++) begin
        last_use[s][w] = 0;
        mv[s][w] = 1'b0;
      end
  endfunction

  function automatic void model_touch(input int s, input int w);
    tick++;
    last_use[s][w] = tick;
  endfunction

  function automatic logic [1:0] model_victim(input int s);
    int best;
    for (int w = 0; w < 4; w++)
      if (!mv[s][w]) return 2'(w);
    best = 0;
    for (int w = 1; w < 4; w++)
      if (last_use[s][w] < last_use[s][best]) best = w;
    return 2'(best);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic count_flush(input string name);
    int n;
    n = 0;
    while (flush_busy && n < 300) begin
      n++;
      @(negedge clk);
    end
    chk(name, n, 64);
    chk({name, "_ready"}, req_ready, 1);
    model_flush();
  endtask

  task automatic wait_ready(output bit ok);
    int n;
    n = 0;
    while (!req_ready && n < 200) begin
      n++;
      @(negedge clk);
    end
    ok = req_ready;
    if (!ok) chk("req_ready_timeout", 0, 1);
  endtask

  task automatic resp_phase(input logic [1:0] ew, input logic em, input int sdel, input string name);
    chk({name, "_resp"}, {resp_valid, resp_way, resp_miss, req_ready}, {1'b1, ew, em, 1'b0});
    repeat (sdel) begin
      @(negedge clk);
      chk({name, "_resp_hold"}, {resp_valid, resp_way, resp_miss, req_ready}, {1'b1, ew, em, 1'b0});
    end
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    chk({name, "_back_idle"}, {resp_valid, req_ready}, {1'b0, 1'b1});
  endtask

  task automatic finish_miss(input logic [5:0] idx, input logic [1:0] ew, input int rdel,
                             input int sdel, input string name);
    chk({name, "_refill"}, {refill_valid, refill_index, refill_way, req_ready}, {1'b1, idx, ew, 1'b0});
    repeat (rdel) begin
      @(negedge clk);
      chk({name, "_refill_hold"}, {refill_valid, refill_index, refill_way, req_ready},
          {1'b1, idx, ew, 1'b0});
    end
    refill_ready = 1'b1;
    @(negedge clk);
    refill_ready = 1'b0;
    repeat ($urandom_range(0, 2)) @(negedge clk);
    chk({name, "_wait"}, {refill_valid, resp_valid}, 2'b00);
    refill_done = 1'b1;
    @(negedge clk);
    refill_done = 1'b0;
    resp_phase(ew, 1'b1, sdel, name);
    mv[idx][ew] = 1'b1;
    model_touch(idx, ew);
  endtask

  task automatic txn(input logic [5:0] idx, input logic hit, input logic [1:0] hway,
                     input logic [1:0] ew, input int rdel, input int sdel, input string name);
    bit ok;
    wait_ready(ok);
    if (!ok) return;
    req_valid   = 1'b1;
    req_index   = idx;
    req_hit     = hit;
    req_hit_way = hit ? hway : 2'($urandom_range(0, 3));
    @(negedge clk);
    req_valid = 1'b0;
    if (hit) begin
      resp_phase(ew, 1'b0, sdel, name);
      model_touch(idx, hway);
    end else begin
      finish_miss(idx, ew, rdel, sdel, name);
    end
  endtask

  typedef struct {
    logic [5:0] idx;
    logic       hit;
    logic [1:0] way;
    int         rdel;
    int         sdel;
    logic [1:0] exp_way;
  } vec_t;

  vec_t tbl [13];

  initial begin
    logic [5:0] ridx;
    logic       rhit;
    logic [1:0] rway;
    bit         ok;
    bit         saw;
    int         n;

    tbl[0]  = '{6'd5,  1'b0, 2'd0, 0, 0, 2'd0};
    tbl[1]  = '{6'd5,  1'b0, 2'd0, 5, 3, 2'd1};
    tbl[2]  = '{6'd5,  1'b0, 2'd0, 1, 0, 2'd2};
    tbl[3]  = '{6'd5,  1'b0, 2'd0, 0, 1, 2'd3};
    tbl[4]  = '{6'd5,  1'b1, 2'd2, 0, 3, 2'd2};
    tbl[5]  = '{6'd5,  1'b1, 2'd0, 0, 0, 2'd0};
    tbl[6]  = '{6'd5,  1'b0, 2'd0, 2, 2, 2'd1};
    tbl[7]  = '{6'd12, 1'b1, 2'd3, 0, 0, 2'd3};
    tbl[8]  = '{6'd12, 1'b0, 2'd0, 0, 0, 2'd0};
    tbl[9]  = '{6'd12, 1'b0, 2'd0, 0, 0, 2'd1};
    tbl[10] = '{6'd12, 1'b0, 2'd0, 0, 0, 2'd2};
    tbl[11] = '{6'd12, 1'b0, 2'd0, 0, 0, 2'd3};
    tbl[12] = '{6'd12, 1'b0, 2'd0, 0, 0, 2'd0};

    repeat (2) @(negedge clk);
    chk("reset_outputs",
        {req_ready, resp_valid, resp_way, resp_miss, refill_valid, refill_index, refill_way, flush_busy},
        {1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 6'd0, 2'd0, 1'b1});
    rst = 1'b0;
    count_flush("reset_flush_len");

    for (int i = 0; i < 13; i++)
      txn(tbl[i].idx, tbl[i].hit, tbl[i].way, tbl[i].exp_way, tbl[i].rdel, tbl[i].sdel,
          $sformatf("vec%0d", i));

    for (int i = 0; i < 150; i++) begin
      ridx = ($urandom_range(0, 3) == 0) ? 6'($urandom_range(0, 63)) : 6'($urandom_range(0, 3));
      rhit = 1'($urandom_range(0, 1));
      rway = 2'($urandom_range(0, 3));
      txn(ridx, rhit, rway, rhit ? rway : model_victim(ridx),
          $urandom_range(0, 3), $urandom_range(0, 3), $sformatf("rnd%0d", i));
    end

    // Flush and request together: flush wins, the held request follows afterwards.
    wait_ready(ok);
    flush_req   = 1'b1;
    req_valid   = 1'b1;
    req_index   = 6'd7;
    req_hit     = 1'b0;
    req_hit_way = 2'd0;
    @(negedge clk);
    flush_req = 1'b0;
    chk("flush_no_accept", {flush_busy, refill_valid}, 2'b10);
    count_flush("flush_req_len");
    @(negedge clk);
    req_valid = 1'b0;
    finish_miss(6'd7, 2'd0, 0, 0, "held_req");

    // Reset while a refill to set 9 is outstanding.
    txn(6'd9, 1'b0, 2'd0, 2'd0, 0, 0, "idx9_first");
    wait_ready(ok);
    req_valid = 1'b1;
    req_index = 6'd9;
    req_hit   = 1'b0;
    @(negedge clk);
    req_valid = 1'b0;
    chk("idx9_second_refill", {refill_valid, refill_index, refill_way}, {1'b1, 6'd9, 2'd1});
    refill_ready = 1'b1;
    @(negedge clk);
    refill_ready = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst         = 1'b0;
    refill_done = 1'b1;
    n   = 0;
    saw = 1'b0;
    while (flush_busy && n < 300) begin
      n++;
      @(negedge clk);
      refill_done = 1'b0;
      if (resp_valid) saw = 1'b1;
    end
    chk("rst_flush_len", n, 64);
    repeat (3) begin
      @(negedge clk);
      if (resp_valid) saw = 1'b1;
    end
    chk("rst_no_resp", saw, 0);
    model_flush();
    txn(6'd9, 1'b0, 2'd0, 2'd0, 0, 0, "idx9_after_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
